spi_mem_txn: RTL and testbench
==============================

// Module: spi_mem_txn
// PURPOSE
//  Memory-side transaction engine: the responder to mem_ctrl's txn interface.
//  - Takes start_read/start_write, a 25-bit address, stall_txn and stop_txn from mem_ctrl.
//  - Runs SPI mode-0 transactions to external flash (addr[24]=0) or RAM (addr[24]=1).
//  - Returns read bytes via data_out/data_ready; fetches write bytes via data_req/data_in.
// PARAMETERS
//  DATA_BUS_WIDTH  8      byte width; only 8 supported
//  READ_CMD        8'h03  SPI opcode for normal read
//  WRITE_CMD       8'h02  SPI opcode for write
//  FAST_READ_CMD   8'h0B  SPI opcode for fast read (SPI_FAST_READ_EN only)
// PORTS
//  clock        in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  start_read   in   1   1-cycle pulse: begin read at addr_in
//  start_write  in   1   1-cycle pulse: begin write at addr_in
//  addr_in      in   25  [24]=chip select (0 flash, 1 RAM), [23:0]=byte address
//  stall_txn    in   1   level: pause at next byte boundary, CS held low
//  stop_txn     in   1   request: end transaction at next byte boundary
//  data_in      in   8   write byte, sampled in the cycle data_req=1
//  data_req     out  1   1-cycle pulse: next write byte is being taken
//  data_out     out  8   last read byte, held until the next byte
//  data_ready   out  1   1-cycle pulse: data_out updated
//  busy         out  1   high from the cycle after start until CS deasserts
//  txn_done     out  1   1-cycle pulse in the cycle CS returns high
//  spi_sclk     out  1   SPI clock, clock/2, idle low
//  spi_mosi     out  1   SPI data out, MSB first
//  spi_miso     in   1   SPI data in
//  spi_cs_flash_n out 1  flash chip select, active low
//  spi_cs_ram_n out  1   RAM chip select, active low
// BEHAVIOUR
//  Reset
//  - sclk=0, mosi=0, both CS=1, data_out=0.
//  - data_ready, data_req, busy and txn_done are 0; FSM is in IDLE.
//  - Reset mid-transaction releases CS immediately, with no txn_done.
//  FSM: IDLE -> CMD(8b) -> ADDR(24b) -> [DUMMY] -> DATA -> (STALL <-> DATA) -> END -> IDLE.
//  Start
//  - Starts are accepted only in IDLE.
//  - Both starts in the same cycle: read wins. Any start while busy is ignored.
//  - On accept, addr_in is latched. In the next cycle the selected CS goes low, busy=1,
//    and MOSI carries the opcode MSB.
//  Bit timing: 2 clocks per bit.
//  - Phase L: sclk=0; MOSI changes only in this phase.
//  - Phase H: sclk=1.
//  - MISO is sampled on the clock edge that ends phase H.
//  - Cost: CMD+ADDR = 64 cycles; each data byte = 16 cycles.
//  Read
//  - After the 8th sampled bit: data_out <= byte and data_ready=1 in the next cycle.
//  - MOSI=0 during data. Bytes stream with the address auto-incrementing in the device.
//  Write
//  - data_req pulses in the first L-phase cycle of each data byte.
//  - data_in is captured in that same cycle and shifted out MSB first.
//  Byte boundary: the cycle after the last H phase of a data byte.
//  - stop_txn is sticky once seen after start. At a boundary with the stop latch set:
//    go to END, CS=1, txn_done=1, busy=0 in that cycle, then IDLE.
//  - Otherwise, if stall_txn=1: go to STALL (sclk=0, CS low, no data_req).
//  - STALL exits to DATA the first cycle stall_txn=0.
//    stop_txn asserted while in STALL ends immediately.
//  - stop_txn during CMD/ADDR/DUMMY ends after the first data byte completes,
//    i.e. at least one data_ready or data_req occurs.
//  - Stop and stall together: stop wins.
//  Idle timing: at least 1 idle cycle (CS high) between transactions.
//  - A start in the txn_done cycle is ignored.
// CONFIGURATION
//  SPI_FAST_READ_EN defined:
//  - Reads use FAST_READ_CMD followed by 8 DUMMY bit-times (16 cycles, MOSI=0, MISO ignored).
//  - The first read byte arrives 16 cycles later than without the macro.
//  SPI_FAST_READ_EN undefined:
//  - Reads use READ_CMD; the DUMMY state is absent.
//  Writes are identical in both builds.
// TESTING
//  1. Reset low mid-ADDR -> both CS=1, sclk=0, busy=0 within the reset cycle; no txn_done.
//  2. start_read, addr=25'h0_012345, MISO model returns 8'hA5 then 8'h3C, stop_txn asserted
//     after the first data_ready:
//     - MOSI=03 01 23 45 on spi_cs_flash_n only.
//     - data_out=A5 with data_ready at cycle 1+64+16 after the start.
//     - Second byte 3C, then txn_done; exactly 2 data_ready pulses.
//  3. start_write, addr=25'h1_000010, data_in=8'h5A then 8'hC3, stop after the 2nd data_req:
//     - MOSI=02 00 00 10 5A C3 on spi_cs_ram_n only.
//     - Exactly 2 data_req pulses, then txn_done.
//  4. Read with stall_txn high for 10 cycles after byte 1:
//     - sclk low and CS low throughout the stall.
//     - Byte 2 resumes with correct data; stop during stall -> CS high the next cycle.
//  5. start_read and start_write in the same cycle, plus a start_read while busy:
//     - Read opcode only; the second start is ignored; one txn_done.
//  6. With SPI_FAST_READ_EN: read addr 25'h0_000000 -> MOSI=0B 00 00 00 + 8 zero bits,
//     and the first data_ready occurs 16 cycles later than in case 2.

Source files
------------

// File: rtl/spi_mem_txn.sv
// spi_mem_txn: memory-side SPI transaction engine.
// Serves start_read/start_write requests from the memory controller as
// SPI mode-0 transactions to the external flash (addr[24]=0) or RAM
// (addr[24]=1). Read bytes are returned on data_out_o/data_ready_o and
// write bytes are fetched on data_req_o/data_in_i.
// Build option: define SPI_FAST_READ_EN to issue FAST_READ_CMD with 8
// dummy bit-times on reads. Writes are the same in both builds.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | CS high, waiting for a start pulse
// S_CMD   | shifting the 8-bit opcode
// S_ADDR  | shifting the 24-bit byte address
// S_DUMMY | 8 dummy bit-times before fast-read data (MOSI=0)
// S_DATA  | one data byte per 8 bit-times, read or write
// S_STALL | paused at a byte boundary, sclk low, CS held low
// S_END   | CS released, txn_done pulse, returns to S_IDLE
module spi_mem_txn #(
   parameter int         DATA_BUS_WIDTH = 8,
   parameter logic [7:0] READ_CMD       = 8'h03,
   parameter logic [7:0] WRITE_CMD      = 8'h02,
   parameter logic [7:0] FAST_READ_CMD  = 8'h0B
) (
   input  logic                      clock_i,
   input  logic                      reset_ni,
   input  logic                      start_read_i,
   input  logic                      start_write_i,
   input  logic [24:0]               addr_in_i,
   input  logic                      stall_txn_i,
   input  logic                      stop_txn_i,
   input  logic [DATA_BUS_WIDTH-1:0] data_in_i,
   output logic                      data_req_o,
   output logic [DATA_BUS_WIDTH-1:0] data_out_o,
   output logic                      data_ready_o,
   output logic                      busy_o,
   output logic                      txn_done_o,
   output logic                      spi_sclk_o,
   output logic                      spi_mosi_o,
   input  logic                      spi_miso_i,
   output logic                      spi_cs_flash_n_o,
   output logic                      spi_cs_ram_n_o
);

`ifdef SPI_FAST_READ_EN
   localparam bit FAST_EN = 1'b1;
`else
   localparam bit FAST_EN = 1'b0;
`endif
   localparam logic [7:0] RD_OP = FAST_EN ? FAST_READ_CMD : READ_CMD;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DUMMY,
      S_DATA,
      S_STALL,
      S_END
   } state_t;

   state_t                    state_q;
   logic                      phase_q;      // 0: L phase (sclk low), 1: H phase
   logic [4:0]                bit_cnt_q;
   logic [30:0]               tx_q;         // bits still to send after the current MOSI bit
   logic [6:0]                rx_q;
   logic                      is_wr_q;
   logic                      stop_q;
   logic                      sclk_q;
   logic                      mosi_q;
   logic                      cs_flash_n_q;
   logic                      cs_ram_n_q;
   logic                      busy_q;
   logic                      txn_done_q;
   logic                      data_ready_q;
   logic                      data_req_q;
   logic [DATA_BUS_WIDTH-1:0] data_out_q;

   logic [7:0]                op_d;
   logic                      stop_d;
   logic                      last_bit_d;

   // Opcode choice at start, sticky stop view, and end-of-field detection.
   always_comb begin
      op_d       = start_read_i ? RD_OP : WRITE_CMD;
      stop_d     = stop_q | stop_txn_i;
      last_bit_d = 1'b0;
      case (state_q)
         S_CMD, S_DUMMY, S_DATA: last_bit_d = (bit_cnt_q == 5'd7);
         S_ADDR:                 last_bit_d = (bit_cnt_q == 5'd23);
         default:                last_bit_d = 1'b0;
      endcase
   end

   // Transaction FSM with registered SPI pins and handshake pulses.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= S_IDLE;
         phase_q      <= 1'b0;
         bit_cnt_q    <= 5'd0;
         tx_q         <= 31'd0;
         rx_q         <= 7'd0;
         is_wr_q      <= 1'b0;
         stop_q       <= 1'b0;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         cs_flash_n_q <= 1'b1;
         cs_ram_n_q   <= 1'b1;
         busy_q       <= 1'b0;
         txn_done_q   <= 1'b0;
         data_ready_q <= 1'b0;
         data_req_q   <= 1'b0;
         data_out_q   <= '0;
      end else begin
         data_ready_q <= 1'b0;
         data_req_q   <= 1'b0;
         txn_done_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // read wins when both starts arrive together
               if (start_read_i || start_write_i) begin
                  is_wr_q      <= ~start_read_i;
                  tx_q         <= {op_d[6:0], addr_in_i[23:0]};
                  mosi_q       <= op_d[7];
                  cs_flash_n_q <= addr_in_i[24];
                  cs_ram_n_q   <= ~addr_in_i[24];
                  busy_q       <= 1'b1;
                  stop_q       <= 1'b0;
                  sclk_q       <= 1'b0;
                  phase_q      <= 1'b0;
                  bit_cnt_q    <= 5'd0;
                  state_q      <= S_CMD;
               end
            end

            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
               stop_q <= stop_d;
               if (!phase_q) begin
                  sclk_q  <= 1'b1;
                  phase_q <= 1'b1;
                  // write byte is taken in the cycle data_req is high;
                  // its MSB is already on MOSI through the output mux
                  if (data_req_q) begin
                     tx_q   <= {data_in_i[6:0], 24'd0};
                     mosi_q <= data_in_i[7];
                  end
               end else begin
                  sclk_q    <= 1'b0;
                  phase_q   <= 1'b0;
                  bit_cnt_q <= bit_cnt_q + 5'd1;
                  tx_q      <= {tx_q[29:0], 1'b0};
                  mosi_q    <= tx_q[30];
                  if (state_q == S_DATA && !is_wr_q) begin
                     rx_q <= {rx_q[5:0], spi_miso_i};
                  end
                  if (last_bit_d) begin
                     bit_cnt_q <= 5'd0;
                     case (state_q)
                        S_CMD: begin
                           state_q <= S_ADDR;
                        end
                        S_ADDR: begin
`ifdef SPI_FAST_READ_EN
                           if (!is_wr_q) begin
                              state_q <= S_DUMMY;
                              mosi_q  <= 1'b0;
                           end else begin
                              state_q    <= S_DATA;
                              data_req_q <= is_wr_q;
                              mosi_q     <= 1'b0;
                           end
`else
                           state_q    <= S_DATA;
                           data_req_q <= is_wr_q;
                           mosi_q     <= 1'b0;
`endif
                        end
                        S_DUMMY: begin
                           state_q    <= S_DATA;
                           data_req_q <= is_wr_q;
                           mosi_q     <= 1'b0;
                        end
                        default: begin
                           // byte boundary: deliver read byte, then stop > stall > next byte
                           if (!is_wr_q) begin
                              data_out_q   <= {rx_q, spi_miso_i};
                              data_ready_q <= 1'b1;
                           end
                           if (stop_d) begin
                              state_q      <= S_END;
                              cs_flash_n_q <= 1'b1;
                              cs_ram_n_q   <= 1'b1;
                              busy_q       <= 1'b0;
                              txn_done_q   <= 1'b1;
                              mosi_q       <= 1'b0;
                              stop_q       <= 1'b0;
                           end else if (stall_txn_i) begin
                              state_q <= S_STALL;
                              mosi_q  <= 1'b0;
                           end else begin
                              state_q    <= S_DATA;
                              data_req_q <= is_wr_q;
                              mosi_q     <= 1'b0;
                           end
                        end
                     endcase
                  end
               end
            end

            S_STALL: begin
               if (stop_d) begin
                  state_q      <= S_END;
                  cs_flash_n_q <= 1'b1;
                  cs_ram_n_q   <= 1'b1;
                  busy_q       <= 1'b0;
                  txn_done_q   <= 1'b1;
                  mosi_q       <= 1'b0;
                  stop_q       <= 1'b0;
               end else if (!stall_txn_i) begin
                  state_q    <= S_DATA;
                  data_req_q <= is_wr_q;
                  mosi_q     <= 1'b0;
               end
            end

            S_END: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // The first bit of a write byte comes straight from data_in so it is
   // valid for the whole L phase in which the byte is requested.
   assign spi_mosi_o       = data_req_q ? data_in_i[7] : mosi_q;
   assign spi_sclk_o       = sclk_q;
   assign spi_cs_flash_n_o = cs_flash_n_q;
   assign spi_cs_ram_n_o   = cs_ram_n_q;
   assign busy_o           = busy_q;
   assign txn_done_o       = txn_done_q;
   assign data_ready_o     = data_ready_q;
   assign data_req_o       = data_req_q;
   assign data_out_o       = data_out_q;

endmodule

// File: tb/tb_spi_mem_txn.sv
// Testbench for spi_mem_txn: directed transactions with a MOSI/read-data
// scoreboard and a simple SPI slave model driving MISO.
module tb_spi_mem_txn;

`ifdef SPI_FAST_READ_EN
   localparam int         FE       = 16;
   localparam logic [7:0] RD_OP    = 8'h0B;
   localparam int         HDR_RD   = 40;
`else
   localparam int         FE       = 0;
   localparam logic [7:0] RD_OP    = 8'h03;
   localparam int         HDR_RD   = 32;
`endif
   localparam logic [7:0] WR_OP    = 8'h02;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_read = 1'b0;
   logic        start_write = 1'b0;
   logic [24:0] addr = '0;
   logic        stall_txn = 1'b0;
   logic        stop_txn = 1'b0;
   logic [7:0]  data_in = '0;
   logic        data_req;
   logic [7:0]  data_out;
   logic        data_ready;
   logic        busy;
   logic        txn_done;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        spi_miso = 1'b1;
   logic        spi_cs_flash_n;
   logic        spi_cs_ram_n;

   always #5 clk = ~clk;

   spi_mem_txn dut (
      .clock_i          (clk),
      .reset_ni         (rst_n),
      .start_read_i     (start_read),
      .start_write_i    (start_write),
      .addr_in_i        (addr),
      .stall_txn_i      (stall_txn),
      .stop_txn_i       (stop_txn),
      .data_in_i        (data_in),
      .data_req_o       (data_req),
      .data_out_o       (data_out),
      .data_ready_o     (data_ready),
      .busy_o           (busy),
      .txn_done_o       (txn_done),
      .spi_sclk_o       (spi_sclk),
      .spi_mosi_o       (spi_mosi),
      .spi_miso_i       (spi_miso),
      .spi_cs_flash_n_o (spi_cs_flash_n),
      .spi_cs_ram_n_o   (spi_cs_ram_n)
   );

   int         checks = 0;
   int         failures = 0;
   int         cyc_cnt = 0;
   int         t_start = 0;
   int         n_ready = 0;
   int         n_req = 0;
   int         n_done = 0;
   bit         seen_flash = 0;
   bit         seen_ram = 0;
   logic [7:0] exp_mosi[$];
   logic [7:0] exp_rd[$];
   logic [7:0] wr_next[$];
   logic [7:0] miso_bytes [4];
   int         hdr_bits = 32;
   int         h_cnt = 0;
   int         mbits = 0;
   logic [7:0] mbyte = '0;
   logic [7:0] mb;
   int         dd;
   bit         req_prev = 0;
   int         lat;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc_cnt++;

   // scoreboard monitor and MISO model, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         h_cnt    = 0;
         mbits    = 0;
         req_prev = 0;
      end else begin
         if (data_ready) begin
            n_ready++;
            check("rd_expected", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) check("rd_data", data_out, exp_rd.pop_front());
         end
         if (data_req) n_req++;
         if (req_prev && wr_next.size() > 0) data_in = wr_next.pop_front();
         req_prev = data_req;
         if (txn_done) n_done++;
         if (!spi_cs_flash_n) seen_flash = 1;
         if (!spi_cs_ram_n) seen_ram = 1;
         if (!spi_cs_flash_n || !spi_cs_ram_n) begin
            if (spi_sclk) begin
               mbyte = {mbyte[6:0], spi_mosi};
               mbits++;
               h_cnt++;
               if (mbits == 8) begin
                  check("mosi_expected", exp_mosi.size() > 0, 1);
                  if (exp_mosi.size() > 0) check("mosi_byte", mbyte, exp_mosi.pop_front());
                  mbits = 0;
               end
            end else begin
               dd = h_cnt - hdr_bits;
               if (dd >= 0 && dd < 32) begin
                  mb = miso_bytes[dd / 8];
                  spi_miso = mb[7 - (dd % 8)];
               end else begin
                  spi_miso = 1'b1;
               end
            end
         end else begin
            h_cnt = 0;
            mbits = 0;
         end
      end
   end

   task automatic start_txn(input logic rd, input logic wr, input logic [24:0] a);
      @(negedge clk);
      start_read  = rd;
      start_write = wr;
      addr        = a;
      @(negedge clk);
      start_read  = 1'b0;
      start_write = 1'b0;
      t_start     = cyc_cnt - 1;
   endtask

   // which: 0 data_ready, 1 data_req, 2 txn_done; lat = cycle index after start
   task automatic wait_for(input int which, input int maxc, input string tag, output int l);
      logic hit;
      hit = 1'b0;
      l   = -1;
      for (int i = 0; i < maxc && !hit; i++) begin
         @(negedge clk);
         case (which)
            0:       hit = data_ready;
            1:       hit = data_req;
            default: hit = txn_done;
         endcase
      end
      if (hit) l = cyc_cnt - t_start;
      else check({tag, "_timeout"}, hit, 1);
   endtask

   task automatic clear_stats();
      n_ready    = 0;
      n_req      = 0;
      n_done     = 0;
      seen_flash = 0;
      seen_ram   = 0;
   endtask

   task automatic end_checks(input string tag, input int e_ready, input int e_req,
                             input int e_done, input bit flash);
      repeat (2) @(negedge clk);
      check({tag, "_ready_cnt"}, n_ready, e_ready);
      check({tag, "_req_cnt"}, n_req, e_req);
      check({tag, "_done_cnt"}, n_done, e_done);
      check({tag, "_flash_used"}, seen_flash, flash);
      check({tag, "_ram_used"}, seen_ram, !flash);
      check({tag, "_mosi_left"}, exp_mosi.size(), 0);
      check({tag, "_rd_left"}, exp_rd.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check("rst_sclk", spi_sclk, 0);
      check("rst_mosi", spi_mosi, 0);
      check("rst_cs_flash", spi_cs_flash_n, 1);
      check("rst_cs_ram", spi_cs_ram_n, 1);
      check("rst_data_out", data_out, 0);
      check("rst_ready", data_ready, 0);
      check("rst_req", data_req, 0);
      check("rst_busy", busy, 0);
      check("rst_done", txn_done, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: reset in the middle of the address phase
      hdr_bits = 32;
      exp_mosi.push_back(WR_OP);
      exp_mosi.push_back(8'hAB);
      clear_stats();
      start_txn(1'b0, 1'b1, 25'h1_ABCDEF);
      check("t1_busy_start", busy, 1);
      repeat (39) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t1_cs_flash", spi_cs_flash_n, 1);
      check("t1_cs_ram", spi_cs_ram_n, 1);
      check("t1_sclk", spi_sclk, 0);
      check("t1_busy", busy, 0);
      check("t1_done", txn_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      end_checks("t1", 0, 0, 0, 1'b0);

      // 2: flash read, two bytes, stop after the first data_ready
      hdr_bits = HDR_RD;
      miso_bytes[0] = 8'hA5;
      miso_bytes[1] = 8'h3C;
      miso_bytes[2] = 8'hFF;
      miso_bytes[3] = 8'hFF;
      exp_mosi = {RD_OP, 8'h01, 8'h23, 8'h45};
      if (FE != 0) exp_mosi.push_back(8'h00);
      exp_mosi.push_back(8'h00);
      exp_mosi.push_back(8'h00);
      exp_rd = {8'hA5, 8'h3C};
      clear_stats();
      start_txn(1'b1, 1'b0, 25'h0_012345);
      check("t2_busy", busy, 1);
      check("t2_cs_flash", spi_cs_flash_n, 0);
      check("t2_cs_ram", spi_cs_ram_n, 1);
      check("t2_mosi_msb", spi_mosi, RD_OP[7]);
      wait_for(0, 300, "t2_ready", lat);
      check("t2_ready_lat", lat, 81 + FE);
      stop_txn = 1'b1;
      wait_for(2, 100, "t2_done", lat);
      stop_txn = 1'b0;
      check("t2_done_lat", lat, 97 + FE);
      check("t2_done_busy", busy, 0);
      check("t2_done_cs", spi_cs_flash_n, 1);
      end_checks("t2", 2, 0, 1, 1'b1);

      // 3: RAM write of two bytes, stop after the second data_req
      hdr_bits = 32;
      data_in  = 8'h5A;
      wr_next  = {8'hC3, 8'h00};
      exp_mosi = {WR_OP, 8'h00, 8'h00, 8'h10, 8'h5A, 8'hC3};
      clear_stats();
      start_txn(1'b0, 1'b1, 25'h1_000010);
      check("t3_cs_ram", spi_cs_ram_n, 0);
      check("t3_cs_flash", spi_cs_flash_n, 1);
      wait_for(1, 200, "t3_req1", lat);
      check("t3_req1_lat", lat, 65);
      wait_for(1, 100, "t3_req2", lat);
      check("t3_req2_lat", lat, 81);
      stop_txn = 1'b1;
      wait_for(2, 100, "t3_done", lat);
      stop_txn = 1'b0;
      check("t3_done_lat", lat, 97);
      end_checks("t3", 0, 2, 1, 1'b0);

      // 4: read with a stall after each byte, stop while stalled
      hdr_bits = HDR_RD;
      miso_bytes[0] = 8'hA1;
      miso_bytes[1] = 8'hB2;
      exp_mosi = {RD_OP, 8'h00, 8'h02, 8'h00};
      if (FE != 0) exp_mosi.push_back(8'h00);
      exp_mosi.push_back(8'h00);
      exp_mosi.push_back(8'h00);
      exp_rd = {8'hA1, 8'hB2};
      clear_stats();
      start_txn(1'b1, 1'b0, 25'h0_000200);
      repeat (60) @(negedge clk);
      stall_txn = 1'b1;
      wait_for(0, 300, "t4_ready1", lat);
      check("t4_ready1_lat", lat, 81 + FE);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t4_stall_sclk", spi_sclk, 0);
         check("t4_stall_cs", spi_cs_flash_n, 0);
      end
      stall_txn = 1'b0;
      @(negedge clk);
      stall_txn = 1'b1;
      wait_for(0, 100, "t4_ready2", lat);
      check("t4_ready2_lat", lat, 108 + FE);
      repeat (3) @(negedge clk);
      check("t4_stall2_sclk", spi_sclk, 0);
      check("t4_stall2_cs", spi_cs_flash_n, 0);
      stop_txn = 1'b1;
      @(negedge clk);
      check("t4_stop_cs", spi_cs_flash_n, 1);
      check("t4_stop_done", txn_done, 1);
      check("t4_stop_busy", busy, 0);
      stop_txn  = 1'b0;
      stall_txn = 1'b0;
      end_checks("t4", 2, 0, 1, 1'b1);

      // 5: simultaneous starts, start while busy, start in the txn_done cycle
      hdr_bits = HDR_RD;
      miso_bytes[0] = 8'h77;
      exp_mosi = {RD_OP, 8'h00, 8'h01, 8'h00};
      if (FE != 0) exp_mosi.push_back(8'h00);
      exp_mosi.push_back(8'h00);
      exp_rd = {8'h77};
      clear_stats();
      start_txn(1'b1, 1'b1, 25'h0_000100);
      stop_txn = 1'b1;
      check("t5_mosi_msb", spi_mosi, RD_OP[7]);
      check("t5_cs_flash", spi_cs_flash_n, 0);
      repeat (2) @(negedge clk);
      stop_txn = 1'b0;
      repeat (7) @(negedge clk);
      start_write = 1'b1;
      addr        = 25'h1_0000FF;
      @(negedge clk);
      start_write = 1'b0;
      wait_for(2, 200, "t5_done", lat);
      check("t5_done_lat", lat, 81 + FE);
      start_read = 1'b1;
      addr       = 25'h0_000300;
      @(negedge clk);
      start_read = 1'b0;
      check("t5_after_busy", busy, 0);
      check("t5_after_cs", spi_cs_flash_n, 1);
      @(negedge clk);
      check("t5_after2_cs", spi_cs_flash_n, 1);
      end_checks("t5", 1, 0, 1, 1'b1);

      // 6: read at address 0 (opcode and dummy phase follow the build)
      hdr_bits = HDR_RD;
      miso_bytes[0] = 8'h5E;
      exp_mosi = {RD_OP, 8'h00, 8'h00, 8'h00};
      if (FE != 0) exp_mosi.push_back(8'h00);
      exp_mosi.push_back(8'h00);
      exp_rd = {8'h5E};
      clear_stats();
      start_txn(1'b1, 1'b0, 25'h0_000000);
      stop_txn = 1'b1;
      @(negedge clk);
      stop_txn = 1'b0;
      wait_for(2, 200, "t6_done", lat);
      check("t6_done_lat", lat, 81 + FE);
      check("t6_data_out", data_out, 8'h5E);
      end_checks("t6", 1, 0, 1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
